// File: rtl/mp_ram_if.sv
// Request/response bundle for the multi-port RAM; vectors packed with port p at slice p.
interface mp_ram_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                   port_req_i;
  logic [NUM_PORTS-1:0]                   port_gnt_o;
  logic [NUM_PORTS-1:0][31:0]             port_addr_i;
  logic [NUM_PORTS-1:0]                   port_we_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] port_be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   port_wdata_i;
  logic [NUM_PORTS-1:0]                   port_rvalid_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   port_rdata_o;
  logic [NUM_PORTS-1:0]                   port_err_o;

  modport master (
    output port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    input  port_gnt_o, port_rvalid_o, port_rdata_o, port_err_o
  );
  modport slave (
    input  port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    output port_gnt_o, port_rvalid_o, port_rdata_o, port_err_o
  );
endinterface

// File: rtl/mp_ram.sv
// Multi-port word RAM: independent ports, byte-enabled writes, per-byte lowest-port-wins
// collisions, read-first, out-of-range errors and registered flag/result shadows.
module mp_ram_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic                  oor,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  rvalid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= req;
      err    <= req & oor;
      // write responses leave rdata untouched
      if (req && !we) rdata <= oor ? '0 : rd_word;
    end
  end
endmodule

module mp_ram #(
  parameter int          NUM_PORTS   = 2,
  parameter int          DEPTH       = 1024,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_0FF8,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0FFC
) (
  input  logic                  clk,
  input  logic                  rst,
  mp_ram_if.slave               bus,
  output logic [DATA_WIDTH-1:0] mem_flag,
  output logic [DATA_WIDTH-1:0] mem_result
);
  localparam int          NB         = DATA_WIDTH / 8;
  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT      = 33'(DEPTH) * 33'(NB);
  localparam logic [AW-1:0] FLAG_IDX = FLAG_ADDR[AW+1:2];
  localparam logic [AW-1:0] RES_IDX  = RESULT_ADDR[AW+1:2];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_PORTS-1:0]                 oor, wr, rv, er;
  logic [NUM_PORTS-1:0][AW-1:0]         idx;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word, rd;

  assign bus.port_gnt_o    = bus.port_req_i;
  assign bus.port_rvalid_o = rv;
  assign bus.port_err_o    = er;
  assign bus.port_rdata_o  = rd;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    assign idx[p]     = bus.port_addr_i[p][AW+1:2];
    assign oor[p]     = {1'b0, bus.port_addr_i[p]} >= LIMIT;
    assign wr[p]      = bus.port_req_i[p] & bus.port_we_i[p] & ~oor[p] & ~rst;
    assign rd_word[p] = mem[idx[p]];

    mp_ram_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.port_req_i[p]),
      .we      (bus.port_we_i[p]),
      .oor     (oor[p]),
      .rd_word (rd_word[p]),
      .rvalid  (rv[p]),
      .err     (er[p]),
      .rdata   (rd[p])
    );
  end

  // Highest port applied first so the lowest-indexed writer's bytes land last.
  always_ff @(posedge clk) begin
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (wr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.port_be_i[p][b]) mem[idx[p]][b*8 +: 8] <= bus.port_wdata_i[p][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_flag   <= '0;
      mem_result <= '0;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        for (int b = 0; b < NB; b++) begin
          if (wr[p] && bus.port_be_i[p][b]) begin
            if (idx[p] == FLAG_IDX) mem_flag[b*8 +: 8]   <= bus.port_wdata_i[p][b*8 +: 8];
            if (idx[p] == RES_IDX)  mem_result[b*8 +: 8] <= bus.port_wdata_i[p][b*8 +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mp_ram.sv
// Randomized and directed check of mp_ram against a word/byte-level reference model.
module tb_mp_ram;
  localparam int          NP    = 2;
  localparam int          DW    = 32;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] FA    = 32'h0000_0FF8;
  localparam logic [31:0] RA    = 32'h0000_0FFC;
  localparam logic [31:0] LIM   = DEPTH * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mp_ram_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();
  logic [DW-1:0] mem_flag, mem_result;

  mp_ram #(.NUM_PORTS(NP), .DEPTH(DEPTH), .DATA_WIDTH(DW), .FLAG_ADDR(FA), .RESULT_ADDR(RA)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .mem_flag   (mem_flag),
    .mem_result (mem_result)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [NP-1:0] exp_rv, exp_err;
  logic [DW-1:0] exp_rd [NP];
  logic [DW-1:0] exp_flag, exp_res;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(int p, bit req, bit we, logic [31:0] a, logic [NB-1:0] be, logic [DW-1:0] wd);
    bus.port_req_i[p]   = req;
    bus.port_we_i[p]    = we;
    bus.port_addr_i[p]  = a;
    bus.port_be_i[p]    = be;
    bus.port_wdata_i[p] = wd;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drv(p, 0, 0, '0, '0, '0);
  endtask

  task automatic check_outs(string t);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_gnt%0d", t, p),    64'(bus.port_gnt_o[p]),    64'(bus.port_req_i[p]));
      chk($sformatf("%s_rvalid%0d", t, p), 64'(bus.port_rvalid_o[p]), 64'(exp_rv[p]));
      chk($sformatf("%s_err%0d", t, p),    64'(bus.port_err_o[p]),    64'(exp_err[p]));
      chk($sformatf("%s_rdata%0d", t, p),  64'(bus.port_rdata_o[p]),  64'(exp_rd[p]));
    end
    chk({t, "_flag"},   64'(mem_flag),   64'(exp_flag));
    chk({t, "_result"}, 64'(mem_result), 64'(exp_res));
  endtask

  // One access cycle: predict from the current model, clock, then compare.
  task automatic cycle(string t);
    bit claimed [int];
    logic [31:0] a;
    int w;
    for (int p = 0; p < NP; p++) begin
      a = bus.port_addr_i[p];
      exp_rv[p]  = bus.port_req_i[p];
      exp_err[p] = bus.port_req_i[p] && (a >= LIM);
      if (bus.port_req_i[p] && !bus.port_we_i[p]) exp_rd[p] = (a >= LIM) ? '0 : ref_mem[a[11:2]];
    end
    for (int p = 0; p < NP; p++) begin
      a = bus.port_addr_i[p];
      if (bus.port_req_i[p] && bus.port_we_i[p] && a < LIM) begin
        w = int'(a[11:2]);
        for (int b = 0; b < NB; b++) begin
          if (bus.port_be_i[p][b] && !claimed.exists(w * NB + b)) begin
            claimed[w * NB + b] = 1'b1;
            ref_mem[w][b*8 +: 8] = bus.port_wdata_i[p][b*8 +: 8];
            if (w == int'(FA[11:2])) exp_flag[b*8 +: 8] = bus.port_wdata_i[p][b*8 +: 8];
            if (w == int'(RA[11:2])) exp_res[b*8 +: 8]  = bus.port_wdata_i[p][b*8 +: 8];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_outs(t);
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < NP; p++)
      drv(p, 1'($urandom), 1'($urandom), $urandom, NB'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_inputs();
    exp_rv = '0; exp_err = '0; exp_flag = '0; exp_res = '0;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    #1;
    check_outs("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outs("rst_hold");
      rand_inputs();
    end
    idle_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rst_release");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = LIM + 32'($urandom_range(0, 255)) * 4;
      1: a = 32'hFFFF_FFFC;
      2: a = FA;
      3: a = RA;
      default: a = 32'($urandom_range(0, 15)) * 4;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  logic [DW-1:0] w0;

  initial begin
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    do_reset();

    // preload every word the random phase can reach
    for (int w = 0; w < 18; w++) begin
      drv(0, 1, 1, (w < 16) ? 32'(w * 4) : 32'((w - 16 + 1022) * 4), '1, $urandom);
      drv(1, 0, 0, '0, '0, '0);
      cycle("init");
    end
    idle_all(); cycle("idle");

    // basic write/read on each port
    drv(0, 1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF); cycle("p0_wr");
    drv(0, 1, 0, 32'h10, 4'h0, 32'h0);         cycle("p0_rd");
    chk("p0_deadbeef", 64'(bus.port_rdata_o[0]), 64'h0000_0000_DEAD_BEEF);
    idle_all();
    drv(1, 1, 1, 32'h14, 4'hF, 32'hCAFE_F00D); cycle("p1_wr");
    drv(1, 1, 0, 32'h14, 4'h0, 32'h0);         cycle("p1_rd");
    chk("p1_cafef00d", 64'(bus.port_rdata_o[1]), 64'h0000_0000_CAFE_F00D);
    idle_all(); cycle("idle");

    // byte enables
    drv(0, 1, 1, 32'h20, 4'hF,    32'h1122_3344); cycle("be_wr1");
    drv(0, 1, 1, 32'h20, 4'b0101, 32'hAABB_CCDD); cycle("be_wr2");
    drv(0, 1, 0, 32'h20, 4'h0,    32'h0);         cycle("be_rd");
    chk("be_merge", 64'(bus.port_rdata_o[0]), 64'h0000_0000_11BB_33DD);

    // write-write and read-during-write collisions
    drv(0, 1, 1, 32'h30, 4'b0001, 32'h0000_00AA);
    drv(1, 1, 1, 32'h30, 4'b1111, 32'hBBBB_BBBB); cycle("ww_col");
    drv(0, 1, 0, 32'h30, 4'h0, 32'h0);
    drv(1, 0, 0, 32'h0,  4'h0, 32'h0);           cycle("ww_rd");
    chk("ww_merge", 64'(bus.port_rdata_o[0]), 64'h0000_0000_BBBB_BBAA);
    drv(0, 1, 0, 32'h30, 4'h0, 32'h0);
    drv(1, 1, 1, 32'h30, 4'hF, 32'h5);           cycle("rw_col");
    chk("read_first", 64'(bus.port_rdata_o[0]), 64'h0000_0000_BBBB_BBAA);
    idle_all(); cycle("idle");

    // out of range
    w0 = ref_mem[0];
    drv(0, 1, 0, 32'h1000, 4'h0, 32'h0); cycle("oor_rd");
    chk("oor_err",   64'(bus.port_err_o[0]),   64'h1);
    chk("oor_rdata", 64'(bus.port_rdata_o[0]), 64'h0);
    drv(0, 1, 1, 32'h1000, 4'hF, 32'h1234_5678); cycle("oor_wr");
    drv(0, 1, 0, 32'h0,    4'h0, 32'h0);         cycle("oor_rd0");
    chk("oor_nowrap", 64'(bus.port_rdata_o[0]), 64'(w0));

    // shadows
    drv(0, 1, 1, FA, 4'hF, 32'h1);
    drv(1, 1, 1, RA, 4'hF, 32'h2A); cycle("shadow_wr");
    chk("shadow_flag",   64'(mem_flag),   64'h1);
    chk("shadow_result", 64'(mem_result), 64'h2A);

    // reset in flight cancels the pending response
    drv(0, 1, 0, 32'h10, 4'h0, 32'h0);
    do_reset();
    chk("rst_flag", 64'(mem_flag), 64'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++)
        drv(p, ($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), NB'($urandom), $urandom);
      cycle("rand");
    end
    idle_all(); cycle("idle_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
